// File: rtl/fp_pkg.sv
// Shared binary16 definitions for the floating-point divider and multiplier:
// field widths, exponent bias, canonical constants and the sequencer state type.
package fp_pkg;

    localparam int FP_N     = 16;
    localparam int FP_EXP_W = 5;
    localparam int FP_MAN_W = 10;
    localparam int FP_BIAS  = 15;

    localparam logic [FP_N-1:0] QNAN    = 16'h7E00;
    localparam logic [FP_N-1:0] POS_INF = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } fp_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: splits a sign-less binary16 magnitude into
// zero / subnormal / infinity / NaN flags.
module fp_classify
    import fp_pkg::*;
#(
    parameter int N     = FP_N,
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic [N-2:0] mag,
    output logic         is_zero,
    output logic         is_sub,
    output logic         is_inf,
    output logic         is_nan
);

    logic exp_max;
    logic exp_zero;
    logic man_zero;

    assign exp_max  = &mag[N-2 -: EXP_W];
    assign exp_zero = ~|mag[N-2 -: EXP_W];
    assign man_zero = ~|mag[MAN_W-1:0];

    assign is_zero = exp_zero & man_zero;
    assign is_sub  = exp_zero & ~man_zero;
    assign is_inf  = exp_max & man_zero;
    assign is_nan  = exp_max & ~man_zero;

endmodule

// File: rtl/fp_divider.sv
// Multi-cycle binary16 divider: restoring division of the significands, one
// quotient bit per cycle. Define FP_DIV_RNE_EN for round-to-nearest-even, else truncation.
module fp_divider
    import fp_pkg::*;
#(
    parameter int N     = FP_N,
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);

    localparam int SIG_W = MAN_W + 1;
    localparam int Q_W   = MAN_W + 3;
    localparam int EW    = 7;
    localparam logic [3:0]           LAST_BIT = 4'(Q_W - 1);
    localparam logic signed [EW-1:0] BIAS_S   = EW'(FP_BIAS);
    localparam logic signed [EW-1:0] ONE_S    = EW'(1);
    localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << EXP_W) - 1);
    localparam logic [N-1:0]         NAN_L    = N'(QNAN);
    localparam logic [N-1:0]         INF_L    = N'(POS_INF);

    fp_state_t              state;
    logic [3:0]             cnt;
    logic                   norm_done;
    logic [N-1:0]           a_r;
    logic [N-1:0]           b_r;
    logic [SIG_W:0]         rem;
    logic [Q_W-1:0]         q;
    logic signed [EW-1:0]   exp_r;

    logic za, sa, ia, na;
    logic zb, sb, ib, nb;

    fp_classify #(.N(N), .EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
        .mag(a_r[N-2:0]), .is_zero(za), .is_sub(sa), .is_inf(ia), .is_nan(na)
    );
    fp_classify #(.N(N), .EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
        .mag(b_r[N-2:0]), .is_zero(zb), .is_sub(sb), .is_inf(ib), .is_nan(nb)
    );

    function automatic logic round_inc(input logic lsb, input logic guard, input logic sticky);
`ifdef FP_DIV_RNE_EN
        return guard & (sticky | lsb);
`else
        return 1'b0 & (lsb | guard | sticky);
`endif
    endfunction

    logic           accept;
    logic [SIG_W:0] divisor;
    logic [SIG_W:0] rem_sub;
    logic           rem_ge;

    assign accept  = in_valid && in_ready;
    assign divisor = {2'b01, b_r[MAN_W-1:0]};
    assign rem_ge  = rem >= divisor;
    assign rem_sub = rem_ge ? rem - divisor : rem;

    logic                 sign;
    logic                 zero_a;
    logic                 zero_b;
    logic [MAN_W-1:0]     mant;
    logic                 guard_bit;
    logic                 sticky_bit;
    logic [MAN_W:0]       mant_rnd;
    logic signed [EW-1:0] exp_fin;
    logic [N-1:0]         res_next;

    // Quotient is normalised with its leading 1 at q[Q_W-1] before rounding
    assign sign       = a_r[N-1] ^ b_r[N-1];
    assign zero_a     = za | sa;
    assign zero_b     = zb | sb;
    assign mant       = q[Q_W-2 -: MAN_W];
    assign guard_bit  = q[1];
    assign sticky_bit = q[0] | (|rem);
    assign mant_rnd   = {1'b0, mant} + {{MAN_W{1'b0}}, round_inc(mant[0], guard_bit, sticky_bit)};
    assign exp_fin    = exp_r + $signed({{(EW-1){1'b0}}, mant_rnd[MAN_W]});

    always_comb begin
        res_next = '0;
        if (na || nb || (zero_a && zero_b) || (ia && ib))
            res_next = NAN_L;
        else if (ia || zero_b)
            res_next = {sign, INF_L[N-2:0]};
        else if (zero_a || ib)
            res_next = {sign, {(N-1){1'b0}}};
        else if (exp_fin <= 0)
            res_next = {sign, {(N-1){1'b0}}};
        else if (exp_fin >= EXP_TOP)
            res_next = {sign, INF_L[N-2:0]};
        else
            res_next = {sign, exp_fin[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_r   <= a;
            b_r   <= b;
            rem   <= {2'b01, a[MAN_W-1:0]};
            q     <= '0;
            exp_r <= $signed(EW'(a[N-2 -: EXP_W])) - $signed(EW'(b[N-2 -: EXP_W])) + BIAS_S;
        end else if (state == DIVIDE) begin
            q   <= {q[Q_W-2:0], rem_ge};
            rem <= rem_sub << 1;
        end else if (state == NORM && !norm_done && !q[Q_W-1]) begin
            q     <= q << 1;
            exp_r <= exp_r - ONE_S;
        end
    end

    // NORM spends one cycle normalising and one cycle rounding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            norm_done <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= DIVIDE;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                    end
                end
                DIVIDE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_BIT) begin
                        state     <= NORM;
                        norm_done <= 1'b0;
                    end
                end
                NORM: begin
                    if (!norm_done) begin
                        norm_done <= 1'b1;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= res_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed cases plus randomized operands
// checked against an arithmetic reference model of binary16 division.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int checks   = 0;
    int failures = 0;

    fp_divider dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] y);
        int     ex, ey, e;
        longint mx, my, num, den, quo, rmd, sig, rest, half;
        int     shift;
        logic   s, xz, yz, xi, yi, xn, yn, up;
        ex = int'(x[14:10]); ey = int'(y[14:10]);
        mx = longint'(x[9:0]); my = longint'(y[9:0]);
        s  = x[15] ^ y[15];
        xz = (ex == 0); yz = (ey == 0);
        xi = (ex == 31) && (mx == 0); yi = (ey == 31) && (my == 0);
        xn = (ex == 31) && (mx != 0); yn = (ey == 31) && (my != 0);
        if (xn || yn || (xz && yz) || (xi && yi)) return 16'h7E00;
        if (xi || yz) return {s, 15'h7C00};
        if (xz || yi) return {s, 15'h0000};
        num = (1024 + mx) << 24;
        den = 1024 + my;
        quo = num / den;
        rmd = num % den;
        e   = ex - ey + 15;
        if (quo >= (longint'(1) << 24)) shift = 14;
        else begin shift = 13; e = e - 1; end
        sig  = quo >> shift;
        rest = quo - (sig << shift);
        half = longint'(1) << (shift - 1);
`ifdef FP_DIV_RNE_EN
        up = (rest > half) || ((rest == half) && ((rmd != 0) || sig[0]));
`else
        up = 1'b0;
`endif
        if (up) sig = sig + 1;
        if (sig == 2048) begin sig = 1024; e = e + 1; end
        if (e <= 0)  return {s, 15'h0000};
        if (e >= 31) return {s, 15'h7C00};
        return {s, 5'(e), 10'(sig - 1024)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accepted_in_ready_low", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result(input string tag, input logic [15:0] expv);
        int lat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk({tag, "_latency"}, 32'(lat), 32'd15);
        chk({tag, "_result"}, 32'(result), 32'(expv));
    endtask

    task automatic release_op(input int hold);
        logic [15:0] held;
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(result), 32'(held));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid_low", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] expv, input int hold);
        start_op(x, y);
        wait_result(tag, expv);
        release_op(hold);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [15:0] r53;
        logic        saw_valid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef FP_DIV_RNE_EN
        r53 = 16'h3EAB;
`else
        r53 = 16'h3EAA;
`endif
        run_op("six_div_two", 16'h4600, 16'h4000, 16'h4200, 0);
        run_op("five_div_three", 16'h4500, 16'h4200, r53, 0);
        run_op("neg_four_div_two", 16'hC400, 16'h4000, 16'hC000, 0);
        run_op("one_div_three", 16'h3C00, 16'h4200, 16'h3555, 0);
        run_op("one_div_zero", 16'h3C00, 16'h0000, 16'h7C00, 0);
        run_op("zero_div_zero", 16'h0000, 16'h0000, 16'h7E00, 0);
        run_op("max_div_subnormal", 16'h7BFF, 16'h0001, 16'h7C00, 0);
        run_op("inf_div_one", 16'h7C00, 16'h3C00, 16'h7C00, 0);
        run_op("one_div_inf", 16'h3C00, 16'h7C00, 16'h0000, 0);
        run_op("inf_div_inf", 16'h7C00, 16'hFC00, 16'h7E00, 0);
        run_op("nan_div_one", 16'h7E01, 16'h3C00, 16'h7E00, 0);
        run_op("negzero_div_one", 16'h8000, 16'h3C00, 16'h8000, 0);
        run_op("one_div_negzero", 16'h3C00, 16'h8000, 16'hFC00, 0);
        run_op("overflow", 16'h7BFF, 16'h0400, 16'h7C00, 0);
        run_op("underflow", 16'h0400, 16'h7BFF, 16'h0000, 0);
        run_op("hold_ten", 16'h4600, 16'h4000, 16'h4200, 10);

        // Reset pulse in the sixth DIVIDE cycle
        start_op(16'h4500, 16'h4200);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_result", 32'(result), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("midreset_no_result", 32'(saw_valid), 32'd0);
        run_op("after_reset", 16'h3C00, 16'h4200, 16'h3555, 0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 2 == 0) begin
                ra = {1'($urandom), 5'($urandom_range(6, 24)), 10'($urandom)};
                rb = {1'($urandom), 5'($urandom_range(6, 24)), 10'($urandom)};
            end
            run_op("random", ra, rb, ref_div(ra, rb), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 SHALL have parameter N, default 16, meaning total operand/result width (IEEE-754 binary16).
REQ-002 SHALL have parameter EXP_W, default 5, meaning exponent field width.
REQ-003 SHALL have parameter MAN_W, default 10, meaning stored mantissa field width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  operands a/b are valid.
REQ-007 SHALL have port in_ready  output  1  divider can accept operands.
REQ-008 SHALL have port a  input  N  dividend, binary16.
REQ-009 SHALL have port b  input  N  divisor, binary16.
REQ-010 SHALL have port out_valid  output  1  result is valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  N  quotient a/b, binary16.

Function
REQ-013 SHALL use FSM states IDLE, DIVIDE, NORM, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-014 SHALL accept operands on an edge where in_valid && in_ready, register a and b, and go IDLE->DIVIDE.
REQ-015 SHALL, in DIVIDE, produce one quotient bit per cycle by restoring division of the 11-bit significands (hidden 1 restored), for exactly 13 cycles, then go to NORM.
REQ-016 SHALL, in NORM, shift left by one and decrement exponent when quotient MSB is 0, form guard and sticky (sticky = remainder nonzero OR dropped bits), round, and go to DONE.
REQ-017 SHALL raise out_valid exactly 15 rising edges after the accepting edge, for every operand class, including special cases.
REQ-018 SHALL hold result and out_valid stable in DONE until out_ready = 1, then return to IDLE on that edge; in_ready SHALL rise the following cycle.
REQ-019 SHALL compute sign = a[N-1] XOR b[N-1] and exponent = ea - eb + 15 (plus normalization/rounding carry), in 7-bit signed arithmetic.
REQ-020 SHALL flush subnormal inputs to signed zero and return signed zero when the final exponent <= 0.
REQ-021 SHALL return signed infinity (exp all ones, mantissa 0) when the final exponent >= 31.
REQ-022 SHALL return 0x7E00 for NaN input, 0/0, or inf/inf; signed inf for x/0 (x nonzero, finite) or inf/finite; signed zero for 0/x or finite/inf.
REQ-023 SHALL propagate a mantissa round-up carry into the exponent, with overflow per REQ-021.

Reset
REQ-024 SHALL, while rst = 1, force state IDLE, in_ready = 1, out_valid = 0, result = 0, independent of clk.
REQ-025 SHALL discard any operation in flight when reset asserts mid-operation; no result is produced for it.

Configuration
REQ-026 SHALL, when FP_DIV_RNE_EN is defined, round to nearest, ties to even, using guard and sticky.
REQ-027 SHALL, when FP_DIV_RNE_EN is undefined, truncate (round toward zero); latency SHALL be unchanged.

Structure
REQ-028 SHALL take N/EXP_W/MAN_W defaults, BIAS = 15, the FSM state enum, and canonical constants (QNAN = 0x7E00, POS_INF = 0x7C00) from a shared package fp_pkg, reused by the multiplier.
REQ-029 SHALL put special-case classification (zero/inf/NaN/subnormal per operand) in one combinational sub-module, fp_classify, instanced once per operand.

Verification
REQ-030 SHALL check: a=0x4600 (6.0), b=0x4000 (2.0) -> result 0x4200 (3.0), out_valid 15 edges after acceptance.
REQ-031 SHALL check: a=0x4500 (5.0), b=0x4200 (3.0) -> 0x3EAB with FP_DIV_RNE_EN, 0x3EAA without.
REQ-032 SHALL check: a=0xC400, b=0x4000 -> 0xC000; a=0x3C00, b=0x4200 -> 0x3555.
REQ-033 SHALL check: a=0x3C00, b=0x0000 -> 0x7C00; a=0x0000, b=0x0000 -> 0x7E00; a=0x7BFF, b=0x0001 -> 0x7C00 (subnormal divisor flushed to zero).
REQ-034 SHALL check: out_ready held low 10 cycles in DONE -> result/out_valid stable, in_ready = 0; back-to-back ops accepted the cycle after the handshake.
REQ-035 SHALL check: rst pulsed at cycle 6 of DIVIDE -> out_valid = 0, result = 0, in_ready = 1 immediately; the next op yields a correct result.
